// File: rtl/arb_memory_if.sv
// Request/response bundle for one arb_memory port.
// The master side issues requests; the slave side returns reads.
interface arb_memory_if #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 9
);
  logic                  valid;
  logic                  ready;
  logic                  wr_rd;
  logic [ADDR_WIDTH-1:0] addr;
  logic [WIDTH-1:0]      wdata;
  logic [WIDTH/8-1:0]    wstrb;
  logic [WIDTH-1:0]      rdata;
  logic                  rvalid;
  logic                  err;

  modport master (
    output valid, wr_rd, addr, wdata, wstrb,
    input  ready, rdata, rvalid, err
  );

  modport slave (
    input  valid, wr_rd, addr, wdata, wstrb,
    output ready, rdata, rvalid, err
  );
endinterface

// File: rtl/arb_memory.sv
// Two-port round-robin arbitrated RAM with byte strobes,
// pipelined reads and out-of-range error pulses.
module arb_memory #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 512,
  parameter int ADDR_WIDTH = 9,
  parameter int RD_LAT     = 1
) (
  input logic         clk_i,
  input logic         rst_i,
  arb_memory_if.slave p0,
  arb_memory_if.slave p1
);
  localparam int NB = WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] LIMIT =
    (ADDR_WIDTH + 1)'(DEPTH);

  typedef struct packed {
    logic             vld;
    logic             port;
    logic             err;
    logic [WIDTH-1:0] data;
  } rd_t;

  logic [WIDTH-1:0] mem [DEPTH];

  logic last_grant;
  logic g0;
  logic g1;
  logic xfer;
  logic sel;
  logic s_wr;
  logic oob;

  logic [ADDR_WIDTH-1:0] s_addr;
  logic [WIDTH-1:0]      s_wdata;
  logic [NB-1:0]         s_wstrb;

  rd_t head;
  rd_t tail;
  rd_t q [RD_LAT];

  logic [1:0]       werr;
  logic [WIDTH-1:0] hold [2];

  // last_grant = 1 means port 1 won last, so port 0 wins a tie
  always_comb begin
    g0 = p0.valid & ~rst_i & (~p1.valid | last_grant);
    g1 = p1.valid & ~rst_i & (~p0.valid | ~last_grant);
  end

  assign p0.ready = g0;
  assign p1.ready = g1;
  assign xfer     = g0 | g1;
  assign sel      = g1;

  always_comb begin
    s_wr    = sel ? p1.wr_rd : p0.wr_rd;
    s_addr  = sel ? p1.addr  : p0.addr;
    s_wdata = sel ? p1.wdata : p0.wdata;
    s_wstrb = sel ? p1.wstrb : p0.wstrb;
    oob     = {1'b0, s_addr} >= LIMIT;
    head      = '0;
    head.vld  = xfer & ~s_wr;
    head.port = sel;
    head.err  = xfer & ~s_wr & oob;
    head.data = oob ? '0 : mem[s_addr];
  end

  always_ff @(posedge clk_i) begin
    if (xfer & s_wr & ~oob) begin
      for (int k = 0; k < NB; k++) begin
        if (s_wstrb[k]) begin
          mem[s_addr][8*k +: 8] <= s_wdata[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_grant <= 1'b1;
      werr       <= '0;
      hold[0]    <= '0;
      hold[1]    <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        q[i] <= '0;
      end
    end else begin
      if (xfer) begin
        last_grant <= sel;
      end
      werr[0] <= xfer & s_wr & oob & ~sel;
      werr[1] <= xfer & s_wr & oob & sel;
      q[0] <= head;
      for (int i = 1; i < RD_LAT; i++) begin
        q[i] <= q[i-1];
      end
      if (tail.vld) begin
        hold[tail.port] <= tail.data;
      end
    end
  end

  // rdata shows the emerging word on its pulse, else the held one
  always_comb begin
    tail = q[RD_LAT-1];
    p0.rvalid = tail.vld & ~tail.port;
    p1.rvalid = tail.vld & tail.port;
    p0.rdata  = p0.rvalid ? tail.data : hold[0];
    p1.rdata  = p1.rvalid ? tail.data : hold[1];
    p0.err    = (tail.err & ~tail.port) | werr[0];
    p1.err    = (tail.err & tail.port) | werr[1];
  end
endmodule

// File: tb/tb_arb_memory.sv
// Bench for arb_memory: two DUTs (RD_LAT 1 and 3) share stimulus
// and are compared every cycle against a word-level model.
module tb_arb_memory;
  localparam int W  = 16;
  localparam int AW = 9;
  localparam int D  = 500;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  arb_memory_if #(.WIDTH(W), .ADDR_WIDTH(AW)) a0 ();
  arb_memory_if #(.WIDTH(W), .ADDR_WIDTH(AW)) a1 ();
  arb_memory_if #(.WIDTH(W), .ADDR_WIDTH(AW)) b0 ();
  arb_memory_if #(.WIDTH(W), .ADDR_WIDTH(AW)) b1 ();

  assign b0.valid = a0.valid;
  assign b0.wr_rd = a0.wr_rd;
  assign b0.addr  = a0.addr;
  assign b0.wdata = a0.wdata;
  assign b0.wstrb = a0.wstrb;
  assign b1.valid = a1.valid;
  assign b1.wr_rd = a1.wr_rd;
  assign b1.addr  = a1.addr;
  assign b1.wdata = a1.wdata;
  assign b1.wstrb = a1.wstrb;

  arb_memory #(
    .WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW), .RD_LAT(1)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .p0(a0), .p1(a1)
  );

  arb_memory #(
    .WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW), .RD_LAT(3)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .p0(b0), .p1(b1)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int lat [2] = '{1, 3};

  logic [15:0] mm [512];
  logic        lg;
  logic        e_rv  [2][2][8];
  logic        e_err [2][2][8];
  logic [15:0] e_dat [2][2][8];
  logic [15:0] e_hold [2][2];
  int          rv_cnt [2][2];
  int          er_cnt [2][2];

  logic        rq_v  [2];
  logic        rq_wr [2];
  logic [8:0]  rq_a  [2];
  logic [15:0] rq_d  [2];
  logic [1:0]  rq_s  [2];
  logic [1:0]  gq [$];

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, want);
    end
  endtask

  task automatic drive();
    a0.valid = rq_v[0];
    a0.wr_rd = rq_wr[0];
    a0.addr  = rq_a[0];
    a0.wdata = rq_d[0];
    a0.wstrb = rq_s[0];
    a1.valid = rq_v[1];
    a1.wr_rd = rq_wr[1];
    a1.addr  = rq_a[1];
    a1.wdata = rq_d[1];
    a1.wstrb = rq_s[1];
  endtask

  task automatic clear_sched();
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        e_hold[d][p] = '0;
        for (int s = 0; s < 8; s++) begin
          e_rv[d][p][s]  = 1'b0;
          e_err[d][p][s] = 1'b0;
          e_dat[d][p][s] = '0;
        end
      end
    end
  endtask

  task automatic clear_cnt();
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        rv_cnt[d][p] = 0;
        er_cnt[d][p] = 0;
      end
    end
  endtask

  task automatic req(int p, logic wr, int addr,
                     logic [15:0] data, logic [1:0] strb);
    rq_v[p]  = 1'b1;
    rq_wr[p] = wr;
    rq_a[p]  = 9'(addr);
    rq_d[p]  = data;
    rq_s[p]  = strb;
  endtask

  // Word-level effect of one accepted request
  task automatic apply(int w);
    logic [8:0] a;
    logic       bad;
    int         s;
    a   = rq_a[w];
    bad = int'(a) >= D;
    if (rq_wr[w]) begin
      if (bad) begin
        for (int d = 0; d < 2; d++) e_err[d][w][(cyc + 1) % 8] = 1'b1;
      end else begin
        for (int k = 0; k < 2; k++) begin
          if (rq_s[w][k]) mm[a][8*k +: 8] = rq_d[w][8*k +: 8];
        end
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        s = (cyc + lat[d]) % 8;
        e_rv[d][w][s]  = 1'b1;
        e_err[d][w][s] = e_err[d][w][s] | bad;
        e_dat[d][w][s] = bad ? 16'h0000 : mm[a];
      end
    end
  endtask

  task automatic tick();
    logic        o_rv [2][2];
    logic        o_er [2][2];
    logic [15:0] o_rd [2][2];
    logic [1:0]  g;
    int          s;
    int          w;
    drive();
    @(negedge clk);
    o_rv[0][0] = a0.rvalid; o_rv[0][1] = a1.rvalid;
    o_rv[1][0] = b0.rvalid; o_rv[1][1] = b1.rvalid;
    o_er[0][0] = a0.err;    o_er[0][1] = a1.err;
    o_er[1][0] = b0.err;    o_er[1][1] = b1.err;
    o_rd[0][0] = a0.rdata;  o_rd[0][1] = a1.rdata;
    o_rd[1][0] = b0.rdata;  o_rd[1][1] = b1.rdata;
    s = cyc % 8;
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        if (e_rv[d][p][s]) e_hold[d][p] = e_dat[d][p][s];
        chk($sformatf("rvalid_d%0d_p%0d_c%0d", d, p, cyc),
            32'(o_rv[d][p]), 32'(e_rv[d][p][s]));
        chk($sformatf("err_d%0d_p%0d_c%0d", d, p, cyc),
            32'(o_er[d][p]), 32'(e_err[d][p][s]));
        chk($sformatf("rdata_d%0d_p%0d_c%0d", d, p, cyc),
            32'(o_rd[d][p]), 32'(e_hold[d][p]));
        if (o_rv[d][p] === 1'b1) rv_cnt[d][p]++;
        if (o_er[d][p] === 1'b1) er_cnt[d][p]++;
        e_rv[d][p][s]  = 1'b0;
        e_err[d][p][s] = 1'b0;
      end
    end
    // lone requester wins; on a tie the port that did not win last
    g = 2'b00;
    if (!rst) begin
      if (rq_v[0] && rq_v[1]) g = lg ? 2'b01 : 2'b10;
      else if (rq_v[0]) g = 2'b01;
      else if (rq_v[1]) g = 2'b10;
    end
    chk($sformatf("ready_a_c%0d", cyc),
        32'({a1.ready, a0.ready}), 32'(g));
    chk($sformatf("ready_b_c%0d", cyc),
        32'({b1.ready, b0.ready}), 32'(g));
    gq.push_back({a1.ready, a0.ready});
    if (g != 2'b00) begin
      w = g[1] ? 1 : 0;
      apply(w);
      rq_v[w] = 1'b0;
      lg = g[1];
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic run_done();
    int n = 0;
    while ((rq_v[0] || rq_v[1]) && n < 40) begin
      tick();
      n++;
    end
    chk("grant_timeout", 32'({rq_v[1], rq_v[0]}), 32'd0);
  endtask

  task automatic do_rst(logic v);
    rst = v;
    if (v) begin
      clear_sched();
      lg = 1'b1;
    end
  endtask

  initial begin
    rst = 1'b1;
    lg  = 1'b1;
    for (int p = 0; p < 2; p++) begin
      rq_v[p] = 1'b0; rq_wr[p] = 1'b0; rq_a[p] = '0;
      rq_d[p] = '0;   rq_s[p] = '0;
    end
    clear_sched();
    clear_cnt();
    idle(2);
    // requests during reset must not be accepted
    req(0, 1'b0, 1, 16'h0, 2'b00);
    req(1, 1'b0, 2, 16'h0, 2'b00);
    tick();
    do_rst(1'b0);
    gq.delete();
    tick();
    chk("first_tie_p0", 32'(gq[0]), 32'h1);
    run_done();
    idle(3);

    for (int i = 0; i < D; i++) begin
      req(i % 2, 1'b1, i, 16'($urandom), 2'b11);
      run_done();
    end
    idle(2);

    // basic write then read
    req(0, 1'b1, 5, 16'hBEEF, 2'b11);
    run_done();
    req(0, 1'b0, 5, 16'h0, 2'b00);
    tick();
    chk("t1_rvalid", 32'(a0.rvalid), 32'h1);
    chk("t1_rdata", 32'(a0.rdata), 32'hBEEF);
    chk("t1_p1_rvalid", 32'(a1.rvalid), 32'h0);
    idle(4);

    // byte strobe merge
    req(0, 1'b1, 7, 16'h1234, 2'b11);
    run_done();
    req(1, 1'b1, 7, 16'hABCD, 2'b01);
    run_done();
    req(1, 1'b0, 7, 16'h0, 2'b00);
    tick();
    chk("t2_rvalid", 32'(a1.rvalid), 32'h1);
    chk("t2_rdata", 32'(a1.rdata), 32'h12CD);
    idle(4);

    // contended reads alternate
    gq.delete();
    clear_cnt();
    req(0, 1'b0, 20, 16'h0, 2'b00);
    req(1, 1'b0, 40, 16'h0, 2'b00);
    tick();
    req(0, 1'b0, 21, 16'h0, 2'b00);
    tick();
    req(1, 1'b0, 41, 16'h0, 2'b00);
    tick();
    tick();
    idle(5);
    chk("t3_g0", 32'(gq[0]), 32'h1);
    chk("t3_g1", 32'(gq[1]), 32'h2);
    chk("t3_g2", 32'(gq[2]), 32'h1);
    chk("t3_g3", 32'(gq[3]), 32'h2);
    chk("t3_cnt_a0", rv_cnt[0][0], 2);
    chk("t3_cnt_a1", rv_cnt[0][1], 2);
    chk("t3_cnt_b0", rv_cnt[1][0], 2);
    chk("t3_cnt_b1", rv_cnt[1][1], 2);

    // same-cycle write and read of one address
    gq.delete();
    req(0, 1'b1, 3, 16'h5555, 2'b11);
    req(1, 1'b0, 3, 16'h0, 2'b00);
    tick();
    tick();
    chk("t4_g0", 32'(gq[0]), 32'h1);
    chk("t4_g1", 32'(gq[1]), 32'h2);
    chk("t4_rdata", 32'(a1.rdata), 32'h5555);
    idle(4);

    // out of range and empty strobe
    clear_cnt();
    req(0, 1'b1, 510, 16'hFFFF, 2'b11);
    run_done();
    req(0, 1'b0, 510, 16'h0, 2'b00);
    run_done();
    idle(4);
    chk("t5_err_a", er_cnt[0][0], 2);
    chk("t5_err_b", er_cnt[1][0], 2);
    req(0, 1'b0, 10, 16'h0, 2'b00);
    run_done();
    req(1, 1'b0, 254, 16'h0, 2'b00);
    run_done();
    req(0, 1'b1, 6, 16'h1111, 2'b00);
    run_done();
    req(1, 1'b0, 6, 16'h0, 2'b00);
    run_done();
    idle(4);
    chk("t5_no_err_p1", er_cnt[0][1], 0);

    // reset while a slow read is in flight
    req(0, 1'b0, 5, 16'h0, 2'b00);
    tick();
    tick();
    do_rst(1'b1);
    tick();
    tick();
    do_rst(1'b0);
    clear_cnt();
    idle(6);
    chk("t6_no_rvalid_b", rv_cnt[1][0], 0);
    req(0, 1'b0, 5, 16'h0, 2'b00);
    run_done();
    idle(4);
    chk("t6_cnt_b", rv_cnt[1][0], 1);

    // random traffic
    repeat (400) begin
      for (int p = 0; p < 2; p++) begin
        if (!rq_v[p] && ($urandom % 3) != 0) begin
          req(p, 1'($urandom % 2), int'($urandom % 512),
              16'($urandom), 2'($urandom % 4));
        end
      end
      tick();
    end
    run_done();
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
